// File: rtl/lfsr_pkg.sv
// Shared definitions for the serial CRC generator/checker pair.
// Holds the checker FSM state encoding and CRC-16 default constants.
// No logic, so there is no latency or backpressure behaviour.
package lfsr_pkg;

    // Default CRC-16 (x^16 + x^15 + x^2 + 1), implicit x^16 term omitted.
    localparam int          CRC16_WIDTH = 16;
    localparam logic [15:0] CRC16_POLY  = 16'h8005;

    // Checker frame FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        REPORT = 2'd2
    } lfsr_state_t;

endpackage

// File: rtl/lfsr_step.sv
// One-bit augmented-form CRC update (long division step), shared by generator and checker.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register r_next.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = CRC16_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = CRC16_POLY
)(
    input  logic [WIDTH-1:0] r,
    input  logic             in,
    output logic [WIDTH-1:0] r_next
);

    // Shift the new bit in; the bit shifted out of the MSB is the x^WIDTH
    // coefficient, which is cancelled by subtracting (XORing) the generator.
    assign r_next = {r[WIDTH-2:0], in} ^ (r[WIDTH-1] ? POLY : '0);

endmodule

// File: rtl/lfsr_check.sv
// Serial CRC frame checker: divides each sof..eof frame (message + CRC) by POLY, reports ok/runt/length.
// Latency: res_valid rises the cycle after the eof bit is accepted.
// Backpressure: in_ready=0 while a result is pending; result held until res_valid && res_ready.
// Optional statistics counters (good/bad/abort) are built when LFSR_CHK_STATS_EN is defined.
module lfsr_check
    import lfsr_pkg::*;
#(
    parameter int               WIDTH   = CRC16_WIDTH,
    parameter logic [WIDTH-1:0] POLY    = CRC16_POLY,
    parameter logic [WIDTH-1:0] INIT    = '0,
    parameter logic [WIDTH-1:0] RESIDUE = '0,
    parameter int               LEN_W   = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_eof,
    output logic             in_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic             res_runt,
    output logic [LEN_W-1:0] res_len
`ifdef LFSR_CHK_STATS_EN
    ,
    output logic [31:0]      good_cnt,
    output logic [31:0]      bad_cnt,
    output logic [31:0]      abort_cnt
`endif
);

    // A frame must hold at least one message bit plus the full CRC.
    localparam logic [LEN_W-1:0] RUNT_LIM = LEN_W'(WIDTH + 1);

    lfsr_state_t      r_state;
    logic [WIDTH-1:0] r_crc;
    logic [LEN_W-1:0] r_len;
    logic             r_res_ok;
    logic             r_res_runt;
    logic [LEN_W-1:0] r_res_len;

    logic             w_acc;
    logic             w_start;
    logic             w_upd;
    logic             w_done;
    logic             w_hs;
    logic [WIDTH-1:0] w_crc_base;
    logic [WIDTH-1:0] w_crc_next;
    logic [LEN_W-1:0] w_len_next;
    logic             w_runt_next;

    assign in_ready  = (r_state != REPORT);
    assign res_valid = (r_state == REPORT);
    assign res_ok    = r_res_ok;
    assign res_runt  = r_res_runt;
    assign res_len   = r_res_len;

    // in_ready already excludes REPORT, so an accepted bit is in IDLE or RECV.
    // sof restarts a frame from either state (an sof in RECV silently aborts).
    assign w_acc   = in_valid && in_ready;
    assign w_start = w_acc && in_sof;
    assign w_upd   = w_start || (w_acc && (r_state == RECV));
    assign w_done  = w_upd && in_eof;
    assign w_hs    = res_valid && res_ready;

    // A starting bit is applied on top of INIT rather than the stale register.
    assign w_crc_base = in_sof ? INIT : r_crc;

    lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .r      (w_crc_base),
        .in     (in),
        .r_next (w_crc_next)
    );

    assign w_len_next  = in_sof ? LEN_W'(1)
                       : ((r_len == '1) ? r_len : r_len + 1'b1);
    assign w_runt_next = (w_len_next < RUNT_LIM);

    // Frame FSM, CRC/length accumulation and result capture at eof.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_crc      <= INIT;
            r_len      <= '0;
            r_res_ok   <= 1'b0;
            r_res_runt <= 1'b0;
            r_res_len  <= '0;
        end else begin
            if (w_upd) begin
                r_crc <= w_crc_next;
                r_len <= w_len_next;
            end
            if (w_done) begin
                r_state    <= REPORT;
                r_res_ok   <= (w_crc_next == RESIDUE) && !w_runt_next;
                r_res_runt <= w_runt_next;
                r_res_len  <= w_len_next;
            end else if (w_start) begin
                r_state <= RECV;
            end else if (w_hs) begin
                r_state    <= IDLE;
                r_res_ok   <= 1'b0;
                r_res_runt <= 1'b0;
                r_res_len  <= '0;
            end
        end
    end

`ifdef LFSR_CHK_STATS_EN
    logic [31:0] r_good_cnt;
    logic [31:0] r_bad_cnt;
    logic [31:0] r_abort_cnt;

    assign good_cnt  = r_good_cnt;
    assign bad_cnt   = r_bad_cnt;
    assign abort_cnt = r_abort_cnt;

    // Saturating frame statistics: outcome per delivered result, aborts per sof in RECV.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (w_hs && r_res_ok && (r_good_cnt != '1)) begin
                r_good_cnt <= r_good_cnt + 1'b1;
            end
            if (w_hs && !r_res_ok && (r_bad_cnt != '1)) begin
                r_bad_cnt <= r_bad_cnt + 1'b1;
            end
            if (w_start && (r_state == RECV) && (r_abort_cnt != '1)) begin
                r_abort_cnt <= r_abort_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_check.sv
// Scoreboard bench for lfsr_check: directed frames push expected results, a monitor pops on handshake.
// Covers good, corrupt, runt, backpressure, abort and mid-frame reset cases.
// Statistics outputs are checked only when LFSR_CHK_STATS_EN is defined.
module tb_lfsr_check;

    typedef struct {
        logic        ok;
        logic        runt;
        logic [15:0] len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in;
    logic        in_valid;
    logic        in_sof;
    logic        in_eof;
    logic        in_ready;
    logic        res_valid;
    logic        res_ready;
    logic        res_ok;
    logic        res_runt;
    logic [15:0] res_len;
`ifdef LFSR_CHK_STATS_EN
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;
    logic [31:0] abort_cnt;
`endif

    exp_t q[$];
    int   total   = 0;
    int   bad     = 0;
    int   n_popped = 0;

    always #5 clk = ~clk;

    lfsr_check dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_eof    (in_eof),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ok    (res_ok),
        .res_runt  (res_runt),
        .res_len   (res_len)
`ifdef LFSR_CHK_STATS_EN
        ,
        .good_cnt  (good_cnt),
        .bad_cnt   (bad_cnt),
        .abort_cnt (abort_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every delivered result against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    n_popped++;
                    chk("res_ok",   {31'd0, res_ok},   {31'd0, e.ok});
                    chk("res_runt", {31'd0, res_runt}, {31'd0, e.runt});
                    chk("res_len",  {16'd0, res_len},  {16'd0, e.len});
                end
            end
        end
    end

    // Present one bit and hold it until accepted (inputs change #1 after posedge).
    task automatic send_bit(input logic b, input logic sof, input logic eof);
        bit done = 0;
        in = b; in_valid = 1'b1; in_sof = sof; in_eof = eof;
        for (int t = 0; t < 200 && !done; t++) begin
            if (in_ready) done = 1;
            @(posedge clk); #1;
        end
        if (!done) chk("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    endtask

    // Send n bits of 'bits' MSB first; eof on the last bit only if use_eof.
    task automatic send_frame(input logic [63:0] bits, input int n, input bit use_eof);
        logic [63:0] v;
        v = bits;
        for (int i = 0; i < n; i++) begin
            send_bit(v[n-1-i], (i == 0), use_eof && (i == n-1));
        end
    endtask

    task automatic expect_res(input logic ok, input logic runt, input logic [15:0] len);
        exp_t e;
        e.ok = ok; e.runt = runt; e.len = len;
        q.push_back(e);
    endtask

    localparam logic [63:0] GOOD    = 64'h0000_0000_0001_8005;
    localparam logic [63:0] CORRUPT = 64'h0000_0000_0011_8005;  // bit 3 of the stream flipped

    initial begin
        rst = 1'b1; in = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_res_ok",    {31'd0, res_ok},    32'd0);
        chk("rst_res_runt",  {31'd0, res_runt},  32'd0);
        chk("rst_res_len",   {16'd0, res_len},   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Stray bits without sof in IDLE are ignored.
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b1);

        // Good frame.
        expect_res(1'b1, 1'b0, 16'd24);
        send_frame(GOOD, 24, 1);

        // Corrupt frame.
        expect_res(1'b0, 1'b0, 16'd24);
        send_frame(CORRUPT, 24, 1);

        // Runt: 16 zeros (residue matches but too short) and a lone sof+eof bit.
        expect_res(1'b0, 1'b1, 16'd16);
        send_frame(64'd0, 16, 1);
        expect_res(1'b0, 1'b1, 16'd1);
        send_bit(1'b0, 1'b1, 1'b1);

        // Backpressure: result held for 10 cycles.
        @(posedge clk); #1;
        res_ready = 1'b0;
        expect_res(1'b1, 1'b0, 16'd24);
        send_frame(GOOD, 24, 1);
        chk("latency_res_valid", {31'd0, res_valid}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_res_ok",    {31'd0, res_ok},    32'd1);
            chk("bp_res_len",   {16'd0, res_len},   32'd24);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_res_valid", {31'd0, res_valid}, 32'd0);
        chk("post_hs_in_ready",  {31'd0, in_ready},  32'd1);
        expect_res(1'b1, 1'b0, 16'd24);
        send_frame(64'd0, 24, 1);

        // Abort: 5-bit partial frame, then sof restarts with the good frame.
        send_frame(64'h15, 5, 0);
        expect_res(1'b1, 1'b0, 16'd24);
        send_frame(GOOD, 24, 1);
`ifdef LFSR_CHK_STATS_EN
        @(posedge clk); #1;
        chk("abort_cnt", abort_cnt, 32'd1);
`endif

        // Reset mid-frame: 10 bits, 1-cycle reset, no result may appear.
        send_frame(64'h3FF, 10, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        end
        @(posedge clk); #1;
        expect_res(1'b1, 1'b0, 16'd24);
        send_frame(GOOD, 24, 1);

        // Drain the scoreboard.
        for (int c = 0; c < 50 && q.size() != 0; c++) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        chk("result_count", n_popped, 32'd1);
`ifdef LFSR_CHK_STATS_EN
        chk("good_cnt", good_cnt, 32'd1);
        chk("bad_cnt",  bad_cnt,  32'd0);
        chk("abort_cnt_after_rst", abort_cnt, 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Results delivered before the mid-frame reset are counted separately.
    int pre_rst_popped = 0;
    initial begin
        @(negedge rst);
        @(posedge rst);
        pre_rst_popped = n_popped;
        n_popped = 0;
        @(negedge rst);
        chk("pre_reset_result_count", pre_rst_popped, 32'd7);
    end

endmodule
